fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: Clock (rising edge) and Reset (active-low, sampled on Clock).
REQ-002 The block SHALL expose parameter OPC_HLT, default 6'h21, the opcode that halts fetching.
REQ-003 The block SHALL have these ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous active-low reset
- IROut  in  16  instruction register contents
- Exec_Ready  in  1  execute stage can accept an instruction
- Exec_Done  in  1  execute stage finished the current instruction
- ARF_OutDSel  out  2  address source (2'b00 = PC)
- ARF_FunSel  out  2  ARF function: 2'b11 clear, 2'b01 increment
- ARF_RegSel  out  3  ARF write enables, one-hot: bit2 PC, bit1 AR, bit0 SP
- Mem_CS  out  1  memory chip select, active-low
- Mem_WR  out  1  memory write (0 = read)
- IR_Write  out  1  IR load enable
- IR_LH  out  1  IR half select: 0 low byte, 1 high byte
- Instr_Valid  out  1  decoded instruction offered to execute stage
- Opcode  out  6  latched IROut[15:10]
- Operand  out  10  latched IROut[9:0]
- Halted  out  1  sequencer stopped on OPC_HLT
- RetireCount  out  16  instructions completed since reset

Function
REQ-004 The FSM states SHALL be CLR_PC, FETCH_LO, FETCH_HI, DECODE, ISSUE, EXEC and HALT; all control outputs are Moore (decoded from state only).
REQ-005 Idle outputs SHALL be: ARF_RegSel=3'b000, ARF_FunSel=2'b00, ARF_OutDSel=2'b00, Mem_CS=1, Mem_WR=0, IR_Write=0, IR_LH=0, Instr_Valid=0. These apply in every state unless overridden below.
REQ-006 CLR_PC SHALL drive ARF_RegSel=3'b100 and ARF_FunSel=2'b11, then go to FETCH_LO.
REQ-007 FETCH_LO SHALL drive Mem_CS=0, Mem_WR=0, ARF_OutDSel=2'b00, IR_Write=1, IR_LH=0, ARF_RegSel=3'b100 and ARF_FunSel=2'b01 (PC increments on the same edge as the IR load), then go to FETCH_HI.
REQ-008 FETCH_HI SHALL drive the same outputs as FETCH_LO except IR_LH=1, then go to DECODE.
REQ-009 DECODE SHALL register Opcode and Operand from IROut, then go to HALT if IROut[15:10]==OPC_HLT, else to ISSUE.
REQ-010 ISSUE SHALL hold Instr_Valid=1 with Opcode and Operand stable, and SHALL go to EXEC on the first edge where Exec_Ready=1.
REQ-011 EXEC SHALL wait for Exec_Done=1, then increment RetireCount and go to FETCH_LO. Exec_Done in any other state SHALL be ignored.
REQ-012 RetireCount SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-013 HALT SHALL assert Halted=1 and drive idle outputs until Reset; Exec_Ready and Exec_Done have no effect in HALT.
REQ-014 Latency: the 4th rising edge after Reset deasserts SHALL assert Instr_Valid (CLR_PC, FETCH_LO, FETCH_HI, DECODE); steady-state fetch-to-issue is 3 cycles.

Reset
REQ-015 With Reset=0 at an edge, the FSM SHALL enter CLR_PC and clear Opcode, Operand, RetireCount and Halted to 0, from any state including mid-fetch and EXEC.
REQ-016 While Reset=0, all control outputs SHALL be idle per REQ-005.

Structure
REQ-017 A shared package SHALL hold the state enumeration, the ARF_FunSel/RegSel/OutDSel encodings and the OPC_HLT default.
REQ-018 The block SHALL be a single module with no sub-modules; the system top instantiates it beside the datapath and wires its outputs to the matching datapath control inputs.

Verification
REQ-019 Set mem[0]=8'h34 and mem[1]=8'h12, then release Reset -> Instr_Valid=1 on the 4th edge, Opcode=6'h04, Operand=10'h234, PC=16'h0002.
REQ-020 Hold Exec_Ready=0 for 5 cycles in ISSUE -> Instr_Valid stays 1 with Opcode and Operand unchanged; set Exec_Ready=1 -> EXEC on the next edge.
REQ-021 Pulse Exec_Done in EXEC -> RetireCount increments 0->1 and FETCH_LO asserts Mem_CS=0, IR_LH=0; an Exec_Done pulse during FETCH_HI leaves RetireCount unchanged.
REQ-022 Set mem[2]=8'h00 and mem[3]=8'h84 after one retired instruction -> Halted=1, Mem_CS=1, and no further PC change over 10 cycles.
REQ-023 Assert Reset=0 during FETCH_HI -> next state is CLR_PC with RetireCount=0, then PC clears to 16'h0000 and refetch starts at address 0.
REQ-024 Force RetireCount to 16'hFFFF and complete one instruction -> RetireCount=16'h0000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared state enumeration and ARF control encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    CLR_PC   = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    DECODE   = 3'd3,
    ISSUE    = 3'd4,
    EXEC     = 3'd5,
    HALT     = 3'd6
  } fetchState_t;

  localparam logic [1:0] ARF_FUN_HOLD  = 2'b00;
  localparam logic [1:0] ARF_FUN_INC   = 2'b01;
  localparam logic [1:0] ARF_FUN_CLEAR = 2'b11;

  localparam logic [2:0] ARF_REG_NONE  = 3'b000;
  localparam logic [2:0] ARF_REG_PC    = 3'b100;
  localparam logic [2:0] ARF_REG_AR    = 3'b010;
  localparam logic [2:0] ARF_REG_SP    = 3'b001;

  localparam logic [1:0] ARF_OUTD_PC   = 2'b00;

  localparam logic [5:0] OPC_HLT_DEFAULT = 6'h21;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Two-byte instruction fetch, decode latch and execute handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [5:0] OPC_HLT = OPC_HLT_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        Exec_Ready,
  input  logic        Exec_Done,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic        Instr_Valid,
  output logic [5:0]  Opcode,
  output logic [9:0]  Operand,
  output logic        Halted,
  output logic [15:0] RetireCount
);

  fetchState_t r_state;
  fetchState_t w_nextState;
  logic [5:0]  r_opcode;
  logic [9:0]  r_operand;
  logic [15:0] r_retireCount;
  logic [15:0] w_retireNext;

  assign w_retireNext = r_retireCount + 16'd1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state       <= CLR_PC;
      r_opcode      <= 6'd0;
      r_operand     <= 10'd0;
      r_retireCount <= 16'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == DECODE) begin
        r_opcode  <= IROut[15:10];
        r_operand <= IROut[9:0];
      end
      if ((r_state == EXEC) && Exec_Done) begin
        r_retireCount <= w_retireNext;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    ARF_OutDSel = ARF_OUTD_PC;
    ARF_FunSel  = ARF_FUN_HOLD;
    ARF_RegSel  = ARF_REG_NONE;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    IR_Write    = 1'b0;
    IR_LH       = 1'b0;
    Instr_Valid = 1'b0;

    case (r_state)
      CLR_PC:   w_nextState = FETCH_LO;
      FETCH_LO: w_nextState = FETCH_HI;
      FETCH_HI: w_nextState = DECODE;
      DECODE:   w_nextState = (IROut[15:10] == OPC_HLT) ? HALT : ISSUE;
      ISSUE:    if (Exec_Ready) w_nextState = EXEC;
      EXEC:     if (Exec_Done) w_nextState = FETCH_LO;
      HALT:     w_nextState = HALT;
      default:  w_nextState = CLR_PC;
    endcase

    // Control outputs stay idle for as long as Reset is held low.
    if (Reset) begin
      case (r_state)
        CLR_PC: begin
          ARF_RegSel = ARF_REG_PC;
          ARF_FunSel = ARF_FUN_CLEAR;
        end
        FETCH_LO, FETCH_HI: begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (r_state == FETCH_HI);
          ARF_RegSel = ARF_REG_PC;
          ARF_FunSel = ARF_FUN_INC;
        end
        ISSUE:   Instr_Valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign Opcode      = r_opcode;
  assign Operand     = r_operand;
  assign RetireCount = r_retireCount;
  assign Halted      = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer with a byte memory, PC and IR model.
`default_nettype none

module tb_fetch_sequencer;

  logic        Clock;
  logic        Reset;
  logic [15:0] IROut;
  logic        Exec_Ready;
  logic        Exec_Done;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic        IR_Write;
  logic        IR_LH;
  logic        Instr_Valid;
  logic [5:0]  Opcode;
  logic [9:0]  Operand;
  logic        Halted;
  logic [15:0] RetireCount;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:255];
  logic [15:0] pc;
  logic [15:0] expQ[$];
  logic [15:0] exp16;

  fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut),
    .Exec_Ready(Exec_Ready), .Exec_Done(Exec_Done),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Write(IR_Write), .IR_LH(IR_LH),
    .Instr_Valid(Instr_Valid), .Opcode(Opcode), .Operand(Operand),
    .Halted(Halted), .RetireCount(RetireCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Datapath model: PC register and byte-wise IR loaded from memory.
  always @(posedge Clock) begin
    if (!Mem_CS && !Mem_WR && IR_Write) begin
      if (IR_LH) IROut[15:8] <= mem[pc[7:0]];
      else       IROut[7:0]  <= mem[pc[7:0]];
    end
    if (ARF_RegSel[2]) begin
      if (ARF_FunSel == 2'b11)      pc <= 16'h0000;
      else if (ARF_FunSel == 2'b01) pc <= pc + 16'd1;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_issue(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (Instr_Valid) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step();
    step();
    total++;
    if (Mem_CS !== 1'b1 || ARF_RegSel !== 3'b000 || ARF_FunSel !== 2'b00 ||
        IR_Write !== 1'b0 || Instr_Valid !== 1'b0 || Mem_WR !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: cs=%b regsel=%b funsel=%b irw=%b valid=%b wr=%b, need 1 000 00 0 0 0",
               Mem_CS, ARF_RegSel, ARF_FunSel, IR_Write, Instr_Valid, Mem_WR);
    end
    total++;
    if (Opcode !== 6'd0 || Operand !== 10'd0 || RetireCount !== 16'd0 || Halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: opc=%h opr=%h rc=%h halt=%b, need zeros",
               Opcode, Operand, RetireCount, Halted);
    end
  endtask

  task automatic test_first_fetch();
    int n;
    expQ.push_back(16'h1234);
    expQ.push_back(16'hA9C3);
    expQ.push_back(16'h03FF);
    Reset = 1'b1;
    wait_issue(10, n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL first_latency: edges=%0d, need 4", n);
    end
    exp16 = expQ.pop_front();
    total++;
    if ({Opcode, Operand} !== exp16) begin
      bad++;
      $display("FAIL first_decode: got %h/%h, need %h/%h", Opcode, Operand, exp16[15:10], exp16[9:0]);
    end
    total++;
    if (pc !== 16'h0002) begin
      bad++;
      $display("FAIL first_pc: pc=%h, need 0002", pc);
    end
  endtask

  task automatic test_issue_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (Instr_Valid !== 1'b1 || {Opcode, Operand} !== exp16) begin
        bad++;
        $display("FAIL issue_hold: valid=%b instr=%h/%h, need 1 %h/%h",
                 Instr_Valid, Opcode, Operand, exp16[15:10], exp16[9:0]);
      end
    end
    Exec_Ready = 1'b1;
    step();
    Exec_Ready = 1'b0;
    total++;
    if (Instr_Valid !== 1'b0 || Mem_CS !== 1'b1) begin
      bad++;
      $display("FAIL issue_to_exec: valid=%b cs=%b, need 0 1", Instr_Valid, Mem_CS);
    end
  endtask

  task automatic test_retire();
    int n;
    step();
    step();
    total++;
    if (RetireCount !== 16'd0 || Mem_CS !== 1'b1) begin
      bad++;
      $display("FAIL exec_wait: rc=%h cs=%b, need 0000 1", RetireCount, Mem_CS);
    end
    Exec_Done = 1'b1;
    step();
    Exec_Done = 1'b0;
    total++;
    if (RetireCount !== 16'd1 || Mem_CS !== 1'b0 || IR_LH !== 1'b0 || IR_Write !== 1'b1) begin
      bad++;
      $display("FAIL retire_fetch_lo: rc=%h cs=%b lh=%b irw=%b, need 0001 0 0 1",
               RetireCount, Mem_CS, IR_LH, IR_Write);
    end
    step();
    Exec_Done = 1'b1;
    step();
    Exec_Done = 1'b0;
    total++;
    if (RetireCount !== 16'd1) begin
      bad++;
      $display("FAIL done_in_fetch_hi: rc=%h, need 0001", RetireCount);
    end
    wait_issue(4, n);
    exp16 = expQ.pop_front();
    total++;
    if (n !== 1 || {Opcode, Operand} !== exp16) begin
      bad++;
      $display("FAIL second_issue: edges=%0d instr=%h/%h, need 1 %h/%h",
               n, Opcode, Operand, exp16[15:10], exp16[9:0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    Exec_Ready = 1'b1;
    Exec_Done  = 1'b1;
    wait_issue(10, n);
    exp16 = expQ.pop_front();
    total++;
    if (n !== 5 || {Opcode, Operand} !== exp16 || RetireCount !== 16'd2) begin
      bad++;
      $display("FAIL b2b_issue: edges=%0d instr=%h/%h rc=%h, need 5 %h/%h 0002",
               n, Opcode, Operand, RetireCount, exp16[15:10], exp16[9:0]);
    end
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (Halted) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== 5 || RetireCount !== 16'd3) begin
      bad++;
      $display("FAIL b2b_halt: edges=%0d rc=%h, need 5 0003", n, RetireCount);
    end
  endtask

  task automatic test_halt();
    logic [15:0] p;
    p = pc;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (pc !== 16'h0008 || p !== 16'h0008 || Halted !== 1'b1 || Mem_CS !== 1'b1 ||
        Instr_Valid !== 1'b0 || RetireCount !== 16'd3) begin
      bad++;
      $display("FAIL halt_hold: pc=%h was=%h halt=%b cs=%b valid=%b rc=%h, need 0008 0008 1 1 0 0003",
               pc, p, Halted, Mem_CS, Instr_Valid, RetireCount);
    end
    Exec_Ready = 1'b0;
    Exec_Done  = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    expQ.push_back(16'h1234);
    expQ.push_back(16'hA9C3);
    expQ.push_back(16'h03FF);
    for (int k = 0; k < 3; k++) begin
      wait_issue(10, n);
      exp16 = expQ.pop_front();
      total++;
      if (n < 1 || {Opcode, Operand} !== exp16) begin
        bad++;
        $display("FAIL wrap_issue%0d: edges=%0d instr=%h/%h, need %h/%h",
                 k, n, Opcode, Operand, exp16[15:10], exp16[9:0]);
      end
      Exec_Ready = 1'b1;
      step();
      Exec_Ready = 1'b0;
      if (k == 0) force dut.w_retireNext = 16'hFFFF;
      Exec_Done = 1'b1;
      step();
      Exec_Done = 1'b0;
      if (k == 0) release dut.w_retireNext;
      total++;
      if (RetireCount !== ((k == 0) ? 16'hFFFF : 16'(k - 1))) begin
        bad++;
        $display("FAIL wrap_count%0d: rc=%h, need %h", k, RetireCount,
                 ((k == 0) ? 16'hFFFF : 16'(k - 1)));
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    step();
    total++;
    if (IR_LH !== 1'b1 || Mem_CS !== 1'b0) begin
      bad++;
      $display("FAIL mid_fetch_hi: lh=%b cs=%b, need 1 0", IR_LH, Mem_CS);
    end
    Reset = 1'b0;
    #1;
    total++;
    if (Mem_CS !== 1'b1 || IR_Write !== 1'b0 || ARF_RegSel !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset_idle: cs=%b irw=%b regsel=%b, need 1 0 000", Mem_CS, IR_Write, ARF_RegSel);
    end
    step();
    total++;
    if (RetireCount !== 16'd0 || Instr_Valid !== 1'b0 || Opcode !== 6'd0) begin
      bad++;
      $display("FAIL mid_reset_clear: rc=%h valid=%b opc=%h, need 0000 0 00", RetireCount, Instr_Valid, Opcode);
    end
    Reset = 1'b1;
    expQ.push_back(16'h1234);
    step();
    total++;
    if (pc !== 16'h0000) begin
      bad++;
      $display("FAIL mid_pc_clear: pc=%h, need 0000", pc);
    end
    wait_issue(10, n);
    exp16 = expQ.pop_front();
    total++;
    if (n !== 3 || {Opcode, Operand} !== exp16 || pc !== 16'h0002) begin
      bad++;
      $display("FAIL refetch: edges=%0d instr=%h/%h pc=%h, need 3 %h/%h 0002",
               n, Opcode, Operand, pc, exp16[15:10], exp16[9:0]);
    end
  endtask

  task automatic test_halt_early();
    int n;
    logic [15:0] p;
    Exec_Ready = 1'b1;
    step();
    Exec_Ready = 1'b0;
    Exec_Done = 1'b1;
    step();
    Exec_Done = 1'b0;
    mem[2] = 8'h00;
    mem[3] = 8'h84;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (Halted) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== 3 || Mem_CS !== 1'b1 || RetireCount !== 16'd1) begin
      bad++;
      $display("FAIL early_halt: edges=%0d cs=%b rc=%h, need 3 1 0001", n, Mem_CS, RetireCount);
    end
    p = pc;
    Exec_Ready = 1'b1;
    Exec_Done  = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (pc !== 16'h0004 || p !== 16'h0004 || Halted !== 1'b1 || RetireCount !== 16'd1) begin
      bad++;
      $display("FAIL early_halt_hold: pc=%h was=%h halt=%b rc=%h, need 0004 0004 1 0001",
               pc, p, Halted, RetireCount);
    end
    Exec_Ready = 1'b0;
    Exec_Done  = 1'b0;
  endtask

  initial begin
    Reset      = 1'b0;
    Exec_Ready = 1'b0;
    Exec_Done  = 1'b0;
    IROut      = 16'h0000;
    pc         = 16'hABCD;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h34; mem[1] = 8'h12;
    mem[2] = 8'hC3; mem[3] = 8'hA9;
    mem[4] = 8'hFF; mem[5] = 8'h03;
    mem[6] = 8'h00; mem[7] = 8'h84;

    test_reset();
    test_first_fetch();
    test_issue_hold();
    test_retire();
    test_back_to_back();
    test_halt();
    test_wrap();
    test_reset_mid_fetch();
    test_halt_early();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
